// File: rtl/uart_pkg.sv
// Shared types and byte constants for the UART register responder.
// The state encoding is fixed so that waveform viewers and checkers agree on it.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    EXEC = 3'd3,
    SEND = 3'd4,
    GAP  = 3'd5
  } resp_state_t;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RESP_OK   = 8'h4B;
  localparam logic [7:0] RESP_ERR  = 8'h45;
  localparam logic [7:0] RESP_BAD  = 8'h3F;

endpackage

// File: rtl/uart_reg_responder.sv
// Parses W/R host commands from received UART bytes, runs them against a small register file,
// and paces one response byte per command so the transmitter is never restarted mid-frame.
module uart_reg_responder
  import uart_pkg::*;
#(
  parameter int BAUD_DIVISOR   = 10416,
  parameter int FRAME_SIZE     = 8,
  parameter int NUM_REGS       = 16,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_complete,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic [15:0] led_value,
  output logic        overrun
);

  localparam int BYTE_CYCLES = BAUD_DIVISOR * (FRAME_SIZE + 2);
  localparam int GAP_W       = $clog2(BYTE_CYCLES) + 1;
  localparam int TO_W        = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // GAP is entered one cycle after tx_start, so the load is one short of a full frame.
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(BYTE_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);
  localparam logic [8:0]       REG_LIMIT = 9'(NUM_REGS);

  resp_state_t      state_r;
  logic [7:0]       cmd_r;
  logic [7:0]       addr_r;
  logic [7:0]       data_r;
  logic [7:0]       tx_data_r;
  logic             tx_start_r;
  logic             overrun_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic [TO_W-1:0]  idle_cnt_r;
  logic [7:0]       regs_r [NUM_REGS];

  logic             addr_ok_s;
  logic [IDX_W-1:0] idx_s;
  logic             wr_en_s;
  logic [7:0]       resp_s;
  logic             busy_s;

  assign tx_data   = tx_data_r;
  assign tx_start  = tx_start_r;
  assign overrun   = overrun_r;
  assign led_value = {regs_r[1], regs_r[0]};

  // Address check and response selection for the command held in cmd/addr/data.
  always_comb begin
    addr_ok_s = ({1'b0, addr_r} < REG_LIMIT);
    idx_s     = addr_r[IDX_W-1:0];
    wr_en_s   = 1'b0;
    resp_s    = RESP_BAD;
    busy_s    = (state_r == EXEC) || (state_r == SEND) || (state_r == GAP);
    case (cmd_r)
      CMD_WRITE: begin
        if (addr_ok_s) begin
          resp_s  = RESP_OK;
          wr_en_s = (state_r == EXEC);
        end else begin
          resp_s  = RESP_ERR;
        end
      end
      CMD_READ: begin
        if (addr_ok_s) begin
          resp_s = regs_r[idx_s];
        end else begin
          resp_s = RESP_ERR;
        end
      end
      default: resp_s = RESP_BAD;
    endcase
  end

  // Command FSM, register file, gap/timeout counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cmd_r      <= 8'h00;
      addr_r     <= 8'h00;
      data_r     <= 8'h00;
      tx_data_r  <= 8'h00;
      tx_start_r <= 1'b0;
      overrun_r  <= 1'b0;
      gap_cnt_r  <= '0;
      idle_cnt_r <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else begin
      tx_start_r <= 1'b0;
      if (rx_complete && busy_s) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (rx_complete) begin
            cmd_r      <= rx_data;
            idle_cnt_r <= '0;
            state_r    <= ((rx_data == CMD_WRITE) || (rx_data == CMD_READ)) ? ADDR : EXEC;
          end
        end
        ADDR: begin
          if (rx_complete) begin
            addr_r     <= rx_data;
            idle_cnt_r <= '0;
            state_r    <= (cmd_r == CMD_WRITE) ? DATA : EXEC;
          end else if (idle_cnt_r == TO_LAST) begin
            state_r <= IDLE;
          end else begin
            idle_cnt_r <= idle_cnt_r + TO_ONE;
          end
        end
        DATA: begin
          if (rx_complete) begin
            data_r     <= rx_data;
            idle_cnt_r <= '0;
            state_r    <= EXEC;
          end else if (idle_cnt_r == TO_LAST) begin
            state_r <= IDLE;
          end else begin
            idle_cnt_r <= idle_cnt_r + TO_ONE;
          end
        end
        EXEC: begin
          if (wr_en_s) begin
            regs_r[idx_s] <= data_r;
          end
          tx_data_r  <= resp_s;
          tx_start_r <= 1'b1;
          state_r    <= SEND;
        end
        SEND: begin
          gap_cnt_r <= GAP_LOAD;
          state_r   <= GAP;
        end
        GAP: begin
          if (gap_cnt_r == '0) begin
            state_r <= IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r - GAP_ONE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Self-checking bench: response bytes are queued when a command is sent and popped by a monitor.
module tb_uart_reg_responder;

  localparam int BAUD   = 4;
  localparam int BYTE_C = BAUD * 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_complete = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [15:0] led_value;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start = 0;
  bit have_prev = 1'b0;
  logic [7:0] exp_q [$];

  uart_reg_responder #(
    .BAUD_DIVISOR(BAUD), .FRAME_SIZE(8), .NUM_REGS(16), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_complete(rx_complete),
    .tx_data(tx_data), .tx_start(tx_start), .led_value(led_value), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Monitor: every tx_start pops the scoreboard and checks pacing.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (tx_start === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tx tx_data=%02h expected no response", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          errors++;
          $display("FAIL tx_data got=%02h expected=%02h", tx_data, e);
        end
      end
      if (have_prev) begin
        checks++;
        if (cyc - last_start < BYTE_C + 1) begin
          errors++;
          $display("FAIL tx_spacing got=%0d expected>=%0d", cyc - last_start, BYTE_C + 1);
        end
      end
      have_prev  = 1'b1;
      last_start = cyc;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_complete = 1'b1;
    @(negedge clk);
    rx_complete = 1'b0;
  endtask

  // Sends the final byte and checks tx_start appears exactly two cycles later.
  task automatic finish_cmd(input logic [7:0] b, input logic [7:0] exp);
    exp_q.push_back(exp);
    send_byte(b);
    checks++;
    if (tx_start !== 1'b0) begin
      errors++;
      $display("FAIL exec_cycle tx_start got=%b expected=0", tx_start);
    end
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1) begin
      errors++;
      $display("FAIL start_cycle tx_start got=%b expected=1", tx_start);
    end
  endtask

  task automatic wait_gap();
    repeat (BYTE_C + 2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_data !== 8'h00 || tx_start !== 1'b0 || led_value !== 16'h0000 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%02h/%b/%04h/%b expected=00/0/0000/0",
               tx_data, tx_start, led_value, overrun);
    end
  endtask

  task automatic test_write();
    send_byte(8'h57);
    send_byte(8'h00);
    finish_cmd(8'hA5, 8'h4B);
    checks++;
    if (led_value !== 16'h00A5) begin
      errors++;
      $display("FAIL write_led got=%04h expected=00a5", led_value);
    end
    wait_gap();
  endtask

  task automatic test_read();
    send_byte(8'h57);
    send_byte(8'h03);
    finish_cmd(8'h3C, 8'h4B);
    wait_gap();
    send_byte(8'h52);
    finish_cmd(8'h03, 8'h3C);
    wait_gap();
    send_byte(8'h52);
    finish_cmd(8'h07, 8'h00);
    wait_gap();
  endtask

  task automatic test_bad_input();
    send_byte(8'h52);
    finish_cmd(8'h10, 8'h45);
    wait_gap();
    send_byte(8'h57);
    send_byte(8'h10);
    finish_cmd(8'hFF, 8'h45);
    checks++;
    if (led_value !== 16'h00A5) begin
      errors++;
      $display("FAIL bad_addr_led got=%04h expected=00a5", led_value);
    end
    wait_gap();
    finish_cmd(8'h41, 8'h3F);
    wait_gap();
  endtask

  task automatic test_timeout();
    send_byte(8'h57);
    send_byte(8'h01);
    repeat (60) @(negedge clk);
    send_byte(8'h52);
    finish_cmd(8'h01, 8'h00);
    checks++;
    if (led_value !== 16'h00A5) begin
      errors++;
      $display("FAIL timeout_led got=%04h expected=00a5", led_value);
    end
    wait_gap();
  endtask

  task automatic test_overrun();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_pre got=%b expected=0", overrun);
    end
    finish_cmd(8'h41, 8'h3F);
    repeat (5) @(negedge clk);
    send_byte(8'h52);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got=%b expected=1", overrun);
    end
    wait_gap();
    // Back-to-back: the next command is accepted right after the gap.
    finish_cmd(8'h41, 8'h3F);
    wait_gap();
  endtask

  task automatic test_back_to_back();
    send_byte(8'h57);
    send_byte(8'h01);
    finish_cmd(8'h77, 8'h4B);
    repeat (BYTE_C) @(negedge clk);
    send_byte(8'h52);
    finish_cmd(8'h01, 8'h77);
    checks++;
    if (led_value !== 16'h77A5) begin
      errors++;
      $display("FAIL b2b_led got=%04h expected=77a5", led_value);
    end
    wait_gap();
  endtask

  task automatic test_reset_mid_cmd();
    send_byte(8'h57);
    send_byte(8'h02);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (tx_data !== 8'h00 || tx_start !== 1'b0 || led_value !== 16'h0000 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs got=%02h/%b/%04h/%b expected=00/0/0000/0",
               tx_data, tx_start, led_value, overrun);
    end
    have_prev = 1'b0;
    repeat (10) @(negedge clk);
    send_byte(8'h57);
    send_byte(8'h00);
    finish_cmd(8'h5A, 8'h4B);
    checks++;
    if (led_value !== 16'h005A) begin
      errors++;
      $display("FAIL post_reset_led got=%04h expected=005a", led_value);
    end
    wait_gap();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_input();
    test_timeout();
    test_overrun();
    test_back_to_back();
    test_reset_mid_cmd();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_responses got=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_reg_responder.md
# uart_reg_responder

Byte-level command responder between `uart_rx_control` and `uart_tx_control`. Parses host commands (write register, read register) from received UART bytes, executes them against an internal 8-bit register file, and emits exactly one response byte per completed command. It paces its own transmit starts so it never issues `tx_start` while the transmitter is still shifting. Registers 0 and 1 are exported for LEDs and other board outputs.

## Interface
- `BAUD_DIVISOR`, 10416: clk cycles per UART bit; same value as given to `uart_tx_control`.
- `FRAME_SIZE`, 8: data bits per frame; must be 8.
- `NUM_REGS`, 16: register count, 1..256.
- `TIMEOUT_CYCLES`, 100_000_000: maximum idle clk cycles between bytes of one command.
- `clk  in  1`: sole clock.
- `rst  in  1`: synchronous, active-high reset.
- `rx_data  in  8`: received byte; valid in the cycle `rx_complete` is high.
- `rx_complete  in  1`: one-cycle pulse per received byte.
- `tx_data  out  8`: response byte to `uart_tx_control`.
- `tx_start  out  1`: one-cycle pulse requesting transmission of `tx_data`.
- `led_value  out  16`: {reg[1], reg[0]}.
- `overrun  out  1`: sticky; a byte was dropped while responding.

## Operation
- Commands: `W` (0x57) addr data, which responds `K` (0x4B); `R` (0x52) addr, which responds with reg[addr].
- `addr >= NUM_REGS`: respond `E` (0x45). No write occurs.
- Any other first byte: respond `?` (0x3F).
- FSM states:
  - IDLE: on rx_complete, latch cmd. `W`/`R` → ADDR; otherwise EXEC with response 0x3F.
  - ADDR: on rx_complete, latch addr. W → DATA; R → EXEC.
  - DATA: on rx_complete, latch data → EXEC.
  - EXEC: perform the write or read and select the response byte; always → SEND.
  - SEND: assert tx_start for 1 cycle, load gap counter → GAP.
  - GAP: count down BYTE_CYCLES = BAUD_DIVISOR*(FRAME_SIZE+2); at 0 → IDLE.
- Timeout: in ADDR/DATA, an idle counter resets on every rx_complete. Reaching TIMEOUT_CYCLES-1 → IDLE, with no response and no write.
- rx_complete in EXEC/SEND/GAP: byte dropped, overrun←1. overrun clears only on rst.
- Register file: NUM_REGS×8, all 0 after reset. Only `W` with a valid addr modifies it.
- Counter widths: $clog2 of the max count + 1. Addr comparison uses the full 8 bits (no truncation to $clog2(NUM_REGS)).

## Timing
- Reset values: tx_data=0x00, tx_start=0, led_value=0x0000, overrun=0, state=IDLE, all registers 0.
- rst mid-command or mid-GAP: next cycle is IDLE with all outputs at reset values. A pending response is abandoned.
- Final command byte's rx_complete at cycle N: EXEC at N+1, tx_start=1 at N+2, next-IDLE at N+3+BYTE_CYCLES.
- Write commit: led_value reflects a write to reg 0/1 at cycle N+2.
- tx_data is registered. It is valid at the tx_start cycle and held until the next tx_start or rst.
- Read-after-write: the following `R` returns the new value. No bypass is needed because of the gap.
- tx_start is never asserted twice within BYTE_CYCLES+1 cycles.

## Structure
- `uart_pkg` holds:
  - the state enum `resp_state_t` (IDLE, ADDR, DATA, EXEC, SEND, GAP);
  - the constants CMD_WRITE=0x57, CMD_READ=0x52, RESP_OK=0x4B, RESP_ERR=0x45, RESP_BAD=0x3F.
- Single module, no sub-module. The register file, gap counter and timeout counter are inline.
- In `top`, the responder is placed between rx and tx control in place of the direct loopback.

## Test plan
Use BAUD_DIVISOR=4, NUM_REGS=16, TIMEOUT_CYCLES=50 for all scenarios.
- Write: bytes 0x57,0x00,0xA5 → one tx_start with tx_data=0x4B two cycles after the last byte; led_value=0x00A5.
- Read: write reg 3=0x3C, then 0x52,0x03 → tx_data=0x3C. Read of reg 7 after reset → 0x00.
- Bad input: 0x52,0x10 → 0x45 with no register change. Lone 0x41 → 0x3F.
- Timeout: 0x57,0x01, then 60 idle cycles, then 0x52,0x01 → only response is 0x00. No 0x4B is ever sent.
- Pacing and overrun: rx_complete during GAP → byte ignored, overrun=1. Consecutive tx_start pulses are ≥41 cycles apart.
- Reset: assert rst during DATA → outputs at reset values next cycle, no tx_start. A following full `W` command works normally.
